// File: rtl/pipeline_control.sv
// Pipeline hazard controller: redirect flush, load-use stall and memory-busy freeze.
// Optional performance counters are enabled by defining PIPELINE_CONTROL_PERF_EN.
module pipeline_control #(
  parameter int FLUSH_DEPTH = 2,
  parameter int LOAD_STALL  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_wb_pc,
  input  logic [31:0] ex_wb_pc_data,
  input  logic [4:0]  ex_mem_command,
  input  logic [4:0]  ex_reg_d,
  input  logic [4:0]  id_reg_s0,
  input  logic [4:0]  id_reg_s1,
  input  logic        id_use_s0,
  input  logic        id_use_s1,
  input  logic        mem_busy,
  output logic        stop,
  output logic        stall_front,
  output logic        bubble_if,
  output logic        bubble_id,
  output logic        pc_load,
  output logic [31:0] pc_load_data,
  output logic [1:0]  ctrl_state
`ifdef PIPELINE_CONTROL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [1:0] RUN    = 2'b00;
  localparam logic [1:0] FLUSH  = 2'b01;
  localparam logic [1:0] LSTALL = 2'b10;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);
  localparam logic [2:0] STALL_LOAD = 3'(LOAD_STALL - 1);

  logic [1:0] state, nxt_state;
  logic [2:0] cnt, nxt_cnt;
  logic       load_use;
  logic       unused_cmd;

  assign unused_cmd = ^ex_mem_command[4:2];

  assign load_use = (ex_mem_command[1:0] == 2'b01) && (ex_reg_d != 5'd0) &&
                    ((id_use_s0 && (id_reg_s0 == ex_reg_d)) ||
                     (id_use_s1 && (id_reg_s1 == ex_reg_d)));

  assign ctrl_state = state;

  always_comb begin
    nxt_state    = state;
    nxt_cnt      = cnt;
    stop         = 1'b0;
    stall_front  = 1'b0;
    bubble_if    = 1'b0;
    bubble_id    = 1'b0;
    pc_load      = 1'b0;
    pc_load_data = 32'd0;
    if (rst) begin
      nxt_state = RUN;
      nxt_cnt   = 3'd0;
    end else if (mem_busy) begin
      stop = 1'b1;
    end else begin
      case (state)
        RUN, LSTALL: begin
          // A redirect overrides any stall: the stalled instruction is on the wrong path.
          if (ex_wb_pc) begin
            pc_load      = 1'b1;
            pc_load_data = ex_wb_pc_data;
            bubble_if    = 1'b1;
            bubble_id    = 1'b1;
            nxt_cnt      = FLUSH_LOAD;
            nxt_state    = (FLUSH_DEPTH > 1) ? FLUSH : RUN;
          end else if (state == RUN) begin
            if (load_use) begin
              stall_front = 1'b1;
              bubble_id   = 1'b1;
              nxt_cnt     = STALL_LOAD;
              nxt_state   = (LOAD_STALL > 1) ? LSTALL : RUN;
            end
          end else begin
            stall_front = 1'b1;
            bubble_id   = 1'b1;
            if (cnt <= 3'd1) begin
              nxt_cnt   = 3'd0;
              nxt_state = RUN;
            end else begin
              nxt_cnt = cnt - 3'd1;
            end
          end
        end
        FLUSH: begin
          bubble_if = 1'b1;
          if (cnt <= 3'd1) begin
            nxt_cnt   = 3'd0;
            nxt_state = RUN;
          end else begin
            nxt_cnt = cnt - 3'd1;
          end
        end
        default: begin
          nxt_state = RUN;
          nxt_cnt   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

`ifdef PIPELINE_CONTROL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (stall_front || stop) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (pc_load)             perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: dut_a uses default depths, dut_b uses LOAD_STALL=3.
module tb_pipeline_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_wb_pc = 1'b0;
  logic [31:0] ex_wb_pc_data = 32'd0;
  logic [4:0]  ex_mem_command = 5'd0;
  logic [4:0]  ex_reg_d = 5'd0;
  logic [4:0]  id_reg_s0 = 5'd0;
  logic [4:0]  id_reg_s1 = 5'd0;
  logic        id_use_s0 = 1'b0;
  logic        id_use_s1 = 1'b0;
  logic        mem_busy = 1'b0;

  logic        a_stop, a_stall, a_bif, a_bid, a_pcl;
  logic [31:0] a_pcd;
  logic [1:0]  a_st;
  logic        b_stop, b_stall, b_bif, b_bid, b_pcl;
  logic [31:0] b_pcd;
  logic [1:0]  b_st;
`ifdef PIPELINE_CONTROL_PERF_EN
  logic [31:0] a_pstall, a_pflush, b_pstall, b_pflush;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_control #(.FLUSH_DEPTH(2), .LOAD_STALL(1)) dut_a (
    .clk(clk), .rst(rst), .ex_wb_pc(ex_wb_pc), .ex_wb_pc_data(ex_wb_pc_data),
    .ex_mem_command(ex_mem_command), .ex_reg_d(ex_reg_d),
    .id_reg_s0(id_reg_s0), .id_reg_s1(id_reg_s1),
    .id_use_s0(id_use_s0), .id_use_s1(id_use_s1), .mem_busy(mem_busy),
    .stop(a_stop), .stall_front(a_stall), .bubble_if(a_bif), .bubble_id(a_bid),
    .pc_load(a_pcl), .pc_load_data(a_pcd), .ctrl_state(a_st)
`ifdef PIPELINE_CONTROL_PERF_EN
    , .perf_stall_cnt(a_pstall), .perf_flush_cnt(a_pflush)
`endif
  );

  pipeline_control #(.FLUSH_DEPTH(2), .LOAD_STALL(3)) dut_b (
    .clk(clk), .rst(rst), .ex_wb_pc(ex_wb_pc), .ex_wb_pc_data(ex_wb_pc_data),
    .ex_mem_command(ex_mem_command), .ex_reg_d(ex_reg_d),
    .id_reg_s0(id_reg_s0), .id_reg_s1(id_reg_s1),
    .id_use_s0(id_use_s0), .id_use_s1(id_use_s1), .mem_busy(mem_busy),
    .stop(b_stop), .stall_front(b_stall), .bubble_if(b_bif), .bubble_id(b_bid),
    .pc_load(b_pcl), .pc_load_data(b_pcd), .ctrl_state(b_st)
`ifdef PIPELINE_CONTROL_PERF_EN
    , .perf_stall_cnt(b_pstall), .perf_flush_cnt(b_pflush)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pack dut_a's single-bit outputs: {stop, stall_front, bubble_if, bubble_id, pc_load}
  function automatic logic [31:0] a_flags();
    return {27'd0, a_stop, a_stall, a_bif, a_bid, a_pcl};
  endfunction

  function automatic logic [31:0] b_flags();
    return {27'd0, b_stop, b_stall, b_bif, b_bid, b_pcl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] cmd, input logic [4:0] rd);
    ex_mem_command = cmd;
    ex_reg_d       = rd;
    id_reg_s1      = 5'd5;
    id_use_s1      = 1'b1;
  endtask

  task automatic clr_in();
    ex_wb_pc       = 1'b0;
    ex_wb_pc_data  = 32'd0;
    ex_mem_command = 5'd0;
    ex_reg_d       = 5'd0;
    id_reg_s0      = 5'd0;
    id_reg_s1      = 5'd0;
    id_use_s0      = 1'b0;
    id_use_s1      = 1'b0;
    mem_busy       = 1'b0;
  endtask

  initial begin
    // reset: outputs all zero even with mem_busy and a redirect requested
    mem_busy = 1'b1; ex_wb_pc = 1'b1; ex_wb_pc_data = 32'hDEAD;
    #1;
    chk("rst_flags", a_flags(), 32'd0);
    chk("rst_pcd",   a_pcd,     32'd0);
    chk("rst_state", a_st,      32'd0);
    clr_in();
    tick();
    rst = 1'b0;
    tick();

    // redirect, FLUSH_DEPTH=2
    ex_wb_pc = 1'b1; ex_wb_pc_data = 32'h0000_0100;
    #1;
    chk("redir0_flags", a_flags(), 32'b00111);
    chk("redir0_pcd",   a_pcd,     32'h100);
    chk("redir0_state", a_st,      32'd0);
    tick(); clr_in(); #1;
    chk("redir1_flags", a_flags(), 32'b00100);
    chk("redir1_pcd",   a_pcd,     32'd0);
    chk("redir1_state", a_st,      32'd1);
    tick();
    chk("redir2_flags", a_flags(), 32'd0);
    chk("redir2_state", a_st,      32'd0);

    // load-use with default LOAD_STALL=1
    set_load_use(5'b00001, 5'd5);
    #1;
    chk("lu0_flags", a_flags(), 32'b01010);
    tick(); clr_in(); #1;
    chk("lu1_flags", a_flags(), 32'd0);
    chk("lu1_state", a_st,      32'd0);
    set_load_use(5'b00001, 5'd0);
    #1;
    chk("lu_rd0_flags", a_flags(), 32'd0);
    set_load_use(5'b00011, 5'd5);
    #1;
    chk("lu_store_flags", a_flags(), 32'd0);
    clr_in();
    ex_mem_command = 5'b00001; ex_reg_d = 5'd9; id_reg_s0 = 5'd9; id_use_s0 = 1'b1;
    #1;
    chk("lu_s0_flags", a_flags(), 32'b01010);
    id_use_s0 = 1'b0;
    #1;
    chk("lu_s0_unused", a_flags(), 32'd0);
    clr_in();

    // redirect and load-use together
    set_load_use(5'b00001, 5'd5);
    ex_wb_pc = 1'b1; ex_wb_pc_data = 32'h0000_2000;
    #1;
    chk("both_flags", a_flags(), 32'b00111);
    chk("both_pcd",   a_pcd,     32'h2000);
    tick(); clr_in(); #1;
    chk("both_state", a_st, 32'd1);
    tick();

    // mem_busy mid-FLUSH
    ex_wb_pc = 1'b1; ex_wb_pc_data = 32'h0000_0040;
    tick(); clr_in(); #1;
    chk("busy_pre_state", a_st, 32'd1);
    mem_busy = 1'b1;
    ex_wb_pc = 1'b1; ex_wb_pc_data = 32'h0000_0080;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_flags", a_flags(), 32'b10000);
      chk("busy_pcd",   a_pcd,     32'd0);
      chk("busy_state", a_st,      32'd1);
      tick();
    end
    clr_in(); #1;
    chk("resume_flags", a_flags(), 32'b00100);
    chk("resume_state", a_st,      32'd1);
    tick();
    chk("resume_end", a_st, 32'd0);

    // LOAD_STALL=3: three stall cycles then RUN
    set_load_use(5'b00001, 5'd5);
    #1;
    chk("ls3_c0_flags", b_flags(), 32'b01010);
    chk("ls3_c0_state", b_st,      32'd0);
    tick(); clr_in(); #1;
    chk("ls3_c1_flags", b_flags(), 32'b01010);
    chk("ls3_c1_state", b_st,      32'd2);
    tick();
    chk("ls3_c2_flags", b_flags(), 32'b01010);
    chk("ls3_c2_state", b_st,      32'd2);
    tick();
    chk("ls3_c3_flags", b_flags(), 32'd0);
    chk("ls3_c3_state", b_st,      32'd0);

    // redirect aborts LSTALL
    set_load_use(5'b00001, 5'd5);
    tick(); clr_in();
    ex_wb_pc = 1'b1; ex_wb_pc_data = 32'h0000_0300;
    #1;
    chk("abort_flags", b_flags(), 32'b00111);
    chk("abort_pcd",   b_pcd,     32'h300);
    tick(); clr_in(); #1;
    chk("abort_state", b_st, 32'd1);
    tick();
    chk("abort_end", b_st, 32'd0);

    // asynchronous reset mid-LSTALL
    set_load_use(5'b00001, 5'd5);
    tick(); clr_in(); #1;
    chk("rstmid_pre", b_st, 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_flags", b_flags(), 32'd0);
    chk("rstmid_state", b_st,      32'd0);
    #1 rst = 1'b0;
    #1;
    chk("rstrel_flags", b_flags(), 32'd0);
    chk("rstrel_state", b_st,      32'd0);
    tick();
    chk("rstrel_next", b_st, 32'd0);

`ifdef PIPELINE_CONTROL_PERF_EN
    rst = 1'b1; #2 rst = 1'b0;
    tick();
    for (int r = 0; r < 2; r++) begin
      ex_wb_pc = 1'b1; ex_wb_pc_data = 32'h0000_0500;
      tick(); clr_in();
      tick();
    end
    set_load_use(5'b00001, 5'd5);
    tick(); clr_in();
    tick();
    chk("perf_flush", a_pflush, 32'd2);
    chk("perf_stall", a_pstall, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter FLUSH_DEPTH, default 2: cycles of front-end kill after a redirect; legal range 1..7.
REQ-002 Parameter LOAD_STALL, default 1: front-end hold cycles per load-use hazard; legal range 1..7.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ex_wb_pc  in  1  execute stage requests PC redirect (taken branch, jal/jalr, fence).
REQ-006 ex_wb_pc_data  in  32  redirect target.
REQ-007 ex_mem_command  in  5  memory command of the instruction at execute inputs: bit0 access, bit1 write.
REQ-008 ex_reg_d  in  5  destination register of the instruction at execute inputs.
REQ-009 id_reg_s0, id_reg_s1  in  5 each  source registers of the instruction in decode.
REQ-010 id_use_s0, id_use_s1  in  1 each  the matching source is actually read.
REQ-011 mem_busy  in  1  memory stage cannot complete this cycle.
REQ-012 stop  out  1  freeze every pipeline register, including execute.
REQ-013 stall_front  out  1  hold PC, fetch and decode registers.
REQ-014 bubble_if  out  1  kill fetch output (decode input becomes NOP).
REQ-015 bubble_id  out  1  kill decode output (execute input becomes NOP).
REQ-016 pc_load  out  1  load PC from pc_load_data.
REQ-017 pc_load_data  out  32  new PC value.
REQ-018 ctrl_state  out  2  RUN=00, FLUSH=01, LSTALL=10; 11 never produced.

Function
REQ-019 load_use = ex_mem_command[1:0]==01, ex_reg_d!=0, and (id_use_s0 with id_reg_s0==ex_reg_d, or id_use_s1 with id_reg_s1==ex_reg_d).
REQ-020 stop = mem_busy, combinational; while stop=1 the state, the counter and the pending target are frozen, and every other output is 0.
REQ-021 Priority when mem_busy=0: redirect > load-use.
REQ-022 RUN with ex_wb_pc=1 drives the following in the same cycle: pc_load=1, pc_load_data=ex_wb_pc_data, bubble_if=1, bubble_id=1.
REQ-023 After a RUN redirect, the counter loads FLUSH_DEPTH-1 and the next state is FLUSH when FLUSH_DEPTH>1, otherwise RUN.
REQ-024 FLUSH: bubble_if=1 and the counter decrements each cycle; on reaching 0 the next state is RUN. ex_wb_pc and load_use are ignored in FLUSH because only killed instructions occupy execute.
REQ-025 RUN with load_use=1 and no redirect drives stall_front=1 and bubble_id=1.
REQ-026 After a RUN load-use stall, the counter loads LOAD_STALL-1 and the next state is LSTALL when LOAD_STALL>1, otherwise RUN.
REQ-027 LSTALL: stall_front=1 and bubble_id=1 while the counter decrements; on 0 the next state is RUN.
REQ-028 LSTALL with ex_wb_pc=1 aborts the stall and acts exactly as REQ-022/REQ-023.
REQ-029 pc_load is a single-cycle pulse per redirect; pc_load_data is 0 whenever pc_load=0.
REQ-030 Counter is 3 bits; it never wraps below 0.

Reset
REQ-031 rst=1 sets the state to RUN and the counter to 0 immediately, without waiting for clk.
REQ-032 While rst=1, all outputs are 0.
REQ-033 rst asserted mid-FLUSH or mid-LSTALL abandons the sequence; the first cycle after release is RUN.

Configuration
REQ-034 Macro PIPELINE_CONTROL_PERF_EN defined adds two output ports:
- perf_stall_cnt [31:0]: +1 per cycle with stall_front=1 or stop=1.
- perf_flush_cnt [31:0]: +1 per pc_load pulse.
REQ-035 Both counters wrap modulo 2^32 and clear on rst.
REQ-036 Macro undefined: the ports and counters are absent, and all other behaviour is identical.

Verification
REQ-037 Redirect, FLUSH_DEPTH=2: ex_wb_pc=1, data=0x0000_0100 for one cycle -> pc_load pulses with 0x100; bubble_if=1 for 2 cycles; bubble_id=1 for cycle 1 only; ctrl_state goes 01 then 00.
REQ-038 Load-use: ex_mem_command=00001, ex_reg_d=5, id_reg_s1=5, id_use_s1=1 -> stall_front=1 and bubble_id=1 for exactly 1 cycle; ex_reg_d=0 with the same stimulus -> no stall.
REQ-039 Simultaneous events: redirect and load-use asserted together -> redirect response only, stall_front=0.
REQ-040 mem_busy=1 for 3 cycles mid-FLUSH -> stop=1 for those cycles, ctrl_state holds 01, and the flush resumes with the remaining count.
REQ-041 Reset mid-sequence: rst pulsed between edges during LSTALL with LOAD_STALL=3 -> outputs drop to 0 asynchronously, and ctrl_state=00 after release.
REQ-042 With PIPELINE_CONTROL_PERF_EN: 2 redirects plus 1 load-use stall -> perf_flush_cnt=2 and perf_stall_cnt=1.
